// File: rtl/iter_divider.sv
// Iterative restoring divider: signed/unsigned, fixed latency of WIDTH+2 edges from
// acceptance to the done cycle, with sign, zero, divide-by-zero and overflow flags.
module iter_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             sf,
    output logic             zf,
    output logic             dzf,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             sf_q, sf_d;
    logic             zf_q, zf_d;
    logic             dzf_q, dzf_d;
    logic             ovf_q, ovf_d;

    // Operand magnitudes at acceptance; |most-negative| still fits as unsigned WIDTH bits.
    logic             a_in_neg, b_in_neg;
    logic [WIDTH-1:0] a_in_mag, b_in_mag;
    // One restoring step: shift next dividend bit into the partial remainder, trial subtract.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    // Sign correction of the magnitude results.
    logic             a_neg_fix, b_neg_fix;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             accept;

    always_comb begin
        a_in_neg  = signed_op & a[WIDTH-1];
        b_in_neg  = signed_op & b[WIDTH-1];
        a_in_mag  = a_in_neg ? -a : a;
        b_in_mag  = b_in_neg ? -b : b;
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        a_neg_fix = sgn_q & a_q[WIDTH-1];
        b_neg_fix = sgn_q & b_q[WIDTH-1];
        q_fix     = (a_neg_fix ^ b_neg_fix) ? -quo_q : quo_q;
        r_fix     = a_neg_fix ? -rem_q : rem_q;
        accept    = start & ((state_q == IDLE) | (state_q == DONE));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        sf_d    = sf_q;
        zf_d    = zf_q;
        dzf_d   = dzf_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = CALC;
                    cnt_d   = CW'(WIDTH);
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = signed_op;
                    quo_d   = a_in_mag;
                    rem_d   = '0;
                    dvs_d   = b_in_mag;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                end else begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (b_q == '0) begin
                    q_out_d = '1;
                    r_out_d = a_q;
                    sf_d    = 1'b0;
                    zf_d    = 1'b0;
                    dzf_d   = 1'b1;
                    ovf_d   = 1'b0;
                end else begin
                    q_out_d = q_fix;
                    r_out_d = r_fix;
                    sf_d    = sgn_q & r_fix[WIDTH-1];
                    zf_d    = (r_fix == '0);
                    dzf_d   = 1'b0;
                    // Only most-negative / -1 overflows; the quotient wraps back to a.
                    ovf_d   = sgn_q & (a_q == {1'b1, {(WIDTH-1){1'b0}}}) & (b_q == '1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            sf_q    <= 1'b0;
            zf_q    <= 1'b0;
            dzf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            sf_q    <= sf_d;
            zf_q    <= zf_d;
            dzf_q   <= dzf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == CALC) | (state_q == FIX);
    assign done = (state_q == DONE);
    assign q    = q_out_q;
    assign r    = r_out_q;
    assign sf   = sf_q;
    assign zf   = zf_q;
    assign dzf  = dzf_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider (WIDTH=8): expected results are queued at issue
// and compared, including the done cycle number, when the done pulse appears.
module tb_iter_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [7:0] r;
    logic       sf;
    logic       zf;
    logic       dzf;
    logic       ovf;

    iter_divider #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .sf        (sf),
        .zf        (zf),
        .dzf       (dzf),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       sf;
        logic       zf;
        logic       dzf;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t last_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [7:0] av, input logic [7:0] bv,
                                   input int c);
        exp_t e;
        int   sa, sbv, qi, ri;
        e.cyc = c;
        e.dzf = 1'b0;
        e.ovf = 1'b0;
        if (bv == 8'h00) begin
            e.q   = 8'hFF;
            e.r   = av;
            e.sf  = 1'b0;
            e.zf  = 1'b0;
            e.dzf = 1'b1;
            return e;
        end
        if (s) begin
            sa    = int'($signed(av));
            sbv   = int'($signed(bv));
            qi    = sa / sbv;
            ri    = sa % sbv;
            e.q   = qi[7:0];
            e.r   = ri[7:0];
            e.ovf = (av == 8'h80) && (bv == 8'hFF);
        end else begin
            e.q = av / bv;
            e.r = av % bv;
        end
        e.sf = s & e.r[7];
        e.zf = (e.r == 8'h00);
        return e;
    endfunction

    // Monitor: one line per completed operation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("q",       32'(q),   32'(mon_e.q));
                check("r",       32'(r),   32'(mon_e.r));
                check("sf",      32'(sf),  32'(mon_e.sf));
                check("zf",      32'(zf),  32'(mon_e.zf));
                check("dzf",     32'(dzf), 32'(mon_e.dzf));
                check("ovf",     32'(ovf), 32'(mon_e.ovf));
                check("latency", 32'(cyc), 32'(mon_e.cyc));
                check("busy_in_done", 32'(busy), 32'd0);
                last_e = mon_e;
                $display("done cyc=%0d q=%02h r=%02h sf=%0b zf=%0b dzf=%0b ovf=%0b",
                         cyc, q, r, sf, zf, dzf, ovf);
            end
        end
    end

    // Called just after a falling edge with the DUT idle or in its done cycle.
    task automatic issue(input logic s, input logic [7:0] av, input logic [7:0] bv);
        start     = 1'b1;
        signed_op = s;
        a         = av;
        b         = bv;
        sb.push_back(model(s, av, bv, cyc + 11));
        @(negedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv);
        issue(s, av, bv);
        drain();
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_q"},    32'(q),    32'd0);
        check({tag, "_r"},    32'(r),    32'd0);
        check({tag, "_flags"}, 32'({sf, zf, dzf, ovf}), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Directed cases from the specification
        run_op(1'b0, 8'd200, 8'd7);
        run_op(1'b1, 8'hF9, 8'h02);
        run_op(1'b0, 8'h2A, 8'h00);
        run_op(1'b1, 8'h2A, 8'h00);
        run_op(1'b1, 8'hD6, 8'h00);
        run_op(1'b1, 8'h80, 8'hFF);
        run_op(1'b0, 8'h80, 8'hFF);
        run_op(1'b1, 8'h80, 8'h01);
        run_op(1'b1, 8'h7F, 8'hFF);
        run_op(1'b1, 8'h07, 8'hFE);
        run_op(1'b0, 8'hFF, 8'h01);

        // Results must hold after done
        repeat (3) @(negedge clk);
        #1;
        check("hold_q", 32'(q), 32'(last_e.q));
        check("hold_r", 32'(r), 32'(last_e.r));

        // Start at edge 3 of a busy operation and operand churn are ignored
        issue(1'b0, 8'd200, 8'd7);
        @(negedge clk);
        #1;
        start     = 1'b1;
        signed_op = 1'b1;
        a         = 8'h13;
        b         = 8'h05;
        @(negedge clk);
        #1;
        start = 1'b0;
        a     = 8'hAA;
        b     = 8'h00;
        drain();
        repeat (15) @(negedge clk);
        #1;

        // Back-to-back: start held in the done cycle
        issue(1'b1, 8'h9C, 8'h0A);
        drain();
        issue(1'b0, 8'd250, 8'd3);
        drain();
        @(negedge clk);
        #1;

        // Random operands, including some zero divisors
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   (i % 6 == 5) ? 8'h00 : 8'($urandom_range(0, 255)));
        end

        // Reset mid-CALC aborts the operation with no done pulse
        issue(1'b0, 8'd123, 8'd5);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        run_op(1'b0, 8'd100, 8'd10);
        check("post_rst_zf", 32'(zf), 32'd1);
        check("post_rst_q",  32'(q),  32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
